// File: rtl/zmod_rx_aligner.sv
// zmod_rx_aligner: zmod LVDS rx word aligner, sync-lane lock FSM and counter-pattern checker
// Clocked by rxdivclk on its rising edge; rst is synchronous and active high.
// Ports:
//   rx_data[31:24] sync lane, rx_data[23:0] data lanes 2..0 (raw ISERDES words)
//   clear_counts   clears err_count, word_count (and err_sticky); wins over a same-edge increment
//   locked, shift  lock status and the bit-slip in use
//   out_valid, out_data  aligned {lane2,lane1,lane0}, two edges after the byte is sampled
//   pat_err        pulse with a valid word that breaks the +1 counter pattern
//   err_count, word_count  saturating counters
// Optional: define ZMOD_RX_STICKY_ERR_EN to add err_sticky (set by pat_err, cleared by rst/clear_counts).
module zmod_rx_aligner #(
  parameter int LOCK_COUNT = 16,
  parameter int LOSS_COUNT = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      rx_data,
  input  logic             clear_counts,
  output logic             locked,
  output logic [2:0]       shift,
  output logic             out_valid,
  output logic [23:0]      out_data,
  output logic             pat_err,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] word_count
`ifdef ZMOD_RX_STICKY_ERR_EN
  ,
  output logic             err_sticky
`endif
);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(LOSS_COUNT + 1);
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;
  state_t state;
  logic [3:0][15:0] hist;
  logic [7:0] sync;
  logic [2:0] cand, cand_shift;
  logic hot, good_lock, lose;
  logic [GW-1:0] good;
  logic [BW-1:0] bad;
  logic [23:0] aligned, d_q, expected;
  logic v_q, lost_q, seeded, mis;
  assign sync = hist[3][7:0];
  assign hot = $onehot(sync);
  always_comb begin
    cand = '0;
    for (int i = 0; i < 8; i++)
      if (sync[i]) cand = 3'(i);
  end
  assign good_lock = hot && cand == shift;
  assign lose = state == LOCKED && !good_lock && bad == BW'(LOSS_COUNT - 1);
  // Each lane keeps the previous byte so any slip 0..7 can straddle two words.
  assign aligned = {8'(hist[2] >> shift), 8'(hist[1] >> shift), 8'(hist[0] >> shift)};
  assign mis = v_q && seeded && d_q != expected;
  always_ff @(posedge clk)
    if (rst) hist <= '0;
    else for (int i = 0; i < 4; i++) hist[i] <= {hist[i][7:0], rx_data[i*8 +: 8]};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HUNT;
      good <= '0;
      bad <= '0;
      cand_shift <= '0;
      shift <= '0;
      locked <= 1'b0;
    end else begin
      case (state)
        HUNT:
          if (hot) begin
            cand_shift <= cand;
            good <= GW'(1);
            if (LOCK_COUNT == 1) begin
              state <= LOCKED;
              shift <= cand;
              locked <= 1'b1;
              bad <= '0;
            end else state <= VERIFY;
          end
        VERIFY:
          if (hot && cand == cand_shift) begin
            good <= good + 1'b1;
            if (good == GW'(LOCK_COUNT - 1)) begin
              state <= LOCKED;
              shift <= cand_shift;
              locked <= 1'b1;
              bad <= '0;
            end
          end else begin
            state <= HUNT;
            good <= '0;
          end
        LOCKED:
          if (good_lock) bad <= '0;
          else if (lose) begin
            state <= HUNT;
            locked <= 1'b0;
            bad <= '0;
            good <= '0;
          end else bad <= bad + 1'b1;
        default: state <= HUNT;
      endcase
    end
  end
  // lost_q travels with the word pipeline so seeding drops in stream order.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= 1'b0;
      d_q <= '0;
      lost_q <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      pat_err <= 1'b0;
      seeded <= 1'b0;
      expected <= '0;
      err_count <= '0;
      word_count <= '0;
    end else begin
      v_q <= state == LOCKED && good_lock;
      d_q <= aligned;
      lost_q <= lose;
      out_valid <= v_q;
      out_data <= d_q;
      pat_err <= mis;
      seeded <= lost_q ? 1'b0 : v_q ? 1'b1 : seeded;
      expected <= v_q ? d_q + 24'd1 : expected;
      err_count <= clear_counts ? '0 : (mis && ~&err_count) ? err_count + 1'b1 : err_count;
      word_count <= clear_counts ? '0 : (v_q && ~&word_count) ? word_count + 1'b1 : word_count;
    end
  end
`ifdef ZMOD_RX_STICKY_ERR_EN
  always_ff @(posedge clk)
    if (rst) err_sticky <= 1'b0;
    else err_sticky <= clear_counts ? 1'b0 : err_sticky | mis;
`endif
endmodule

// File: tb/tb_zmod_rx_aligner.sv
// tb_zmod_rx_aligner: directed and randomized self-checking bench for zmod_rx_aligner
module tb_zmod_rx_aligner;
  localparam int LOCK = 16;
  localparam int LOSS = 4;
  logic clk = 1'b0;
  logic rst, clear_counts, locked, out_valid, pat_err, err_sticky;
  logic [31:0] rx_data;
  logic [2:0] shift;
  logic [23:0] out_data;
  logic [31:0] err_count, word_count;
  always #5 clk = ~clk;
  zmod_rx_aligner #(.LOCK_COUNT(LOCK), .LOSS_COUNT(LOSS), .CNT_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .clear_counts(clear_counts),
    .locked(locked),
    .shift(shift),
    .out_valid(out_valid),
    .out_data(out_data),
    .pat_err(pat_err),
    .err_count(err_count),
    .word_count(word_count)
`ifdef ZMOD_RX_STICKY_ERR_EN
    ,
    .err_sticky(err_sticky)
`endif
  );
  int checks = 0;
  int errors = 0;
  bit mlocked, pv, plost, seeded, e_valid, e_err, e_st, e_rst;
  int mshift, run, cshift, badrun;
  logic [23:0] pd, mexp, e_data;
  logic [31:0] p1, p2, e_ec, e_wc, tx_prev;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    mlocked = 0; pv = 0; plost = 0; seeded = 0; e_valid = 0; e_err = 0; e_st = 0; e_rst = 1;
    mshift = 0; run = 0; cshift = 0; badrun = 0;
    pd = 0; mexp = 0; e_data = 0; p1 = 0; p2 = 0; e_ec = 0; e_wc = 0;
  endtask
  task automatic model_edge(input logic [31:0] v, input bit clr);
    logic [7:0] s;
    logic [15:0] x;
    logic [23:0] w;
    bit hot;
    int cand;
    e_rst = 0;
    e_valid = pv;
    e_err = 0;
    if (pv) begin
      e_data = pd;
      e_err = seeded && pd != mexp;
      mexp = pd + 24'd1;
      seeded = 1;
    end
    if (plost) seeded = 0;
    e_wc = clr ? 0 : (pv && e_wc != 32'hFFFFFFFF) ? e_wc + 1 : e_wc;
    e_ec = clr ? 0 : (e_err && e_ec != 32'hFFFFFFFF) ? e_ec + 1 : e_ec;
    e_st = clr ? 0 : e_st | e_err;
    s = p1[31:24];
    hot = $countones(s) == 1;
    cand = hot ? $clog2(s) : -1;
    for (int i = 0; i < 3; i++) begin
      x = {p2[i*8 +: 8], p1[i*8 +: 8]} >> mshift;
      w[i*8 +: 8] = x[7:0];
    end
    pv = 0;
    plost = 0;
    if (!mlocked) begin
      if (run == 0) begin
        if (hot) begin run = 1; cshift = cand; end
      end else if (hot && cand == cshift) run++;
      else run = 0;
      if (run == LOCK) begin mlocked = 1; mshift = cshift; run = 0; badrun = 0; end
    end else begin
      pv = hot && cand == mshift;
      if (pv) badrun = 0;
      else begin
        badrun++;
        if (badrun == LOSS) begin mlocked = 0; badrun = 0; plost = 1; end
      end
    end
    pd = w;
    p2 = p1;
    p1 = v;
  endtask
  task automatic compare_all();
    chk("locked", locked, mlocked);
    chk("shift", shift, mshift[2:0]);
    chk("out_valid", out_valid, e_valid);
    chk("pat_err", pat_err, e_err);
    chk("err_count", err_count, e_ec);
    chk("word_count", word_count, e_wc);
    if (e_valid || e_rst) chk("out_data", out_data, e_data);
`ifdef ZMOD_RX_STICKY_ERR_EN
    chk("err_sticky", err_sticky, e_st);
`endif
  endtask
  task automatic step(input logic [31:0] v, input bit clr, input bit r);
    rx_data = v;
    clear_counts = clr;
    rst = r;
    @(posedge clk);
    if (r) model_reset();
    else model_edge(v, clr);
    #1;
    compare_all();
  endtask
  function automatic logic [31:0] rot(input logic [31:0] p, input logic [31:0] c, input int r);
    logic [15:0] x;
    rot = c;
    if (r != 0)
      for (int i = 0; i < 4; i++) begin
        x = {p[i*8 +: 8], c[i*8 +: 8]} << r;
        rot[i*8 +: 8] = x[15:8];
      end
  endfunction
  task automatic send(input logic [7:0] s, input logic [23:0] d, input int r, input bit clr);
    logic [31:0] cur;
    cur = {s, d};
    step(rot(tx_prev, cur, r), clr, 0);
    tx_prev = cur;
  endtask
  task automatic do_reset();
    step(32'h0, 0, 1);
    tx_prev = 0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
  initial begin
    int off, n, r;
    logic [23:0] base, d;
    logic [7:0] s;
    rst = 1; rx_data = 0; clear_counts = 0; tx_prev = 0;
    do_reset();
    do_reset();
    chk("reset_locked", locked, 0);
    chk("reset_out_data", out_data, 0);
    for (int i = 0; i < 40; i++) begin
      send(8'h01, 24'(i), 0, 0);
      if (i == 15) chk("t1_not_yet_locked", locked, 0);
      if (i == 16) chk("t1_locked", locked, 1);
      if (i == 18) begin
        chk("t1_first_valid", out_valid, 1);
        chk("t1_first_word", out_data, 24'h10);
      end
    end
    chk("t1_shift", shift, 0);
    chk("t1_err_count", err_count, 0);
    do_reset();
    for (int i = 0; i < 40; i++) send(8'h01, 24'(i), 3, 0);
    chk("t2_shift", shift, 3);
    chk("t2_err_count", err_count, 0);
    for (int i = 40; i < 'h110; i++) send(8'h01, (i == 'h105) ? 24'h185 : 24'(i), 3, 0);
    chk("t3_err_count", err_count, 2);
`ifdef ZMOD_RX_STICKY_ERR_EN
    chk("t3_sticky_set", err_sticky, 1);
`endif
    send(8'h01, 24'h110, 3, 1);
`ifdef ZMOD_RX_STICKY_ERR_EN
    chk("t3_sticky_cleared", err_sticky, 0);
`endif
    do_reset();
    d = 0;
    for (int i = 0; i < 30; i++) begin send(8'h01, d, 0, 0); d++; end
    for (int i = 0; i < 3; i++) begin send(8'h00, d, 0, 0); d++; end
    send(8'h01, d, 0, 0); d++;
    chk("t4_hold_after_3_bad", locked, 1);
    for (int i = 0; i < 10; i++) begin send(8'h01, d, 0, 0); d++; end
    for (int i = 0; i < 4; i++) begin send(8'h00, d, 0, 0); d++; end
    for (int j = 0; j < 21; j++) begin
      send(8'h01, d, 0, 0);
      d++;
      if (j == 0) chk("t4_lost", locked, 0);
      if (j == 15) chk("t4_not_relocked", locked, 0);
      if (j == 16) chk("t4_relocked", locked, 1);
    end
    do_reset();
    d = 24'hFFFFE0;
    for (int i = 0; i < 48; i++) begin send(8'h01, d, 0, 0); d++; end
    chk("t5_wrap_no_err", err_count, 0);
    send(8'h01, d ^ 24'h000400, 0, 0); d++;
    send(8'h01, d, 0, 0); d++;
    send(8'h01, d, 0, 1); d++;
    chk("t5_clear_pat_err", pat_err, 1);
    chk("t5_clear_err_count", err_count, 0);
    chk("t5_clear_word_count", word_count, 0);
    for (int i = 0; i < 4; i++) begin send(8'h01, d, 0, 0); d++; end
    do_reset();
    off = 0;
    for (int i = 0; i < 60; i++) begin
      if (i >= 30 && i <= 46 && (i - 30) % 4 == 0) off += 16;
      send(8'h01, 24'(i + off), 5, 0);
    end
    chk("t6_shift", shift, 5);
    chk("t6_err_count", err_count, 5);
    step(32'h01000000, 0, 1);
    chk("t6_rst_locked", locked, 0);
    chk("t6_rst_shift", shift, 0);
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_err_count", err_count, 0);
    chk("t6_rst_word_count", word_count, 0);
    for (int k = 0; k < 8; k++) begin
      do_reset();
      r = $urandom_range(0, 7);
      base = 24'($urandom);
      n = $urandom_range(60, 150);
      for (int i = 0; i < n; i++) begin
        s = ($urandom_range(0, 29) == 0) ? 8'($urandom) : 8'h01;
        d = base + 24'(i);
        if ($urandom_range(0, 19) == 0) d = d ^ (24'd1 << $urandom_range(0, 23));
        send(s, d, r, $urandom_range(0, 39) == 0);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
